// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue.
// Buffers inst/pc4 pairs; flush on redirect; NOP when empty.
module if_id_queue #(
  parameter int DEPTH = 2,
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            in_valid,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc4,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_pc4,
  input  logic            out_ready,
  output logic [PTRW:0]   count
);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_t;

  localparam logic [PTRW:0] CNT_FULL =
    (PTRW+1)'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   count_q;
  logic [PTRW:0]   count_nxt;
  occ_t            occ;
  logic            push;
  logic            pop;

  // Occupancy class derived from the counter.
  always_comb begin
    occ = PARTIAL;
    unique case (1'b1)
      (count_q == '0):       occ = EMPTY;
      (count_q == CNT_FULL): occ = FULL;
      default:               occ = PARTIAL;
    endcase
  end

  assign in_ready  = (occ != FULL) & ~Rst;
  assign out_valid = (occ != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Head entry, forced to NOP when nothing is queued.
  always_comb begin
    out_inst = '0;
    out_pc4  = '0;
    if (out_valid) begin
      out_inst = inst_mem[rd_ptr];
      out_pc4  = pc4_mem[rd_ptr];
    end
  end

  // Next occupancy; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count_q;
    unique case (1'b1)
      (push & ~pop): count_nxt = count_q + 1'b1;
      (pop & ~push): count_nxt = count_q - 1'b1;
      default:       count_nxt = count_q;
    endcase
  end

  // Storage is never cleared; gating hides stale words.
  always_ff @(posedge Clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc4_mem[wr_ptr]  <= in_pc4;
    end
  end

  // Pointer/count state; reset beats flush, flush beats traffic.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      count_q <= count_nxt;
    end
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage of the CPU. It holds fetched instruction words and their PC+4 values in a small FIFO. Decode can stall without stalling fetch for up to DEPTH instructions. A branch or jump redirect flushes all queued words in one cycle. When the queue is empty, it presents a NOP (all zeros) so that decode always sees a legal instruction word.

## Interface
- DEPTH, 2: number of entries; a power of two, at least 2.
- PTRW, log2(DEPTH): pointer width; derived from DEPTH, not overridden.

- Clk  input  1  rising-edge clock shared with fetch and decode.
- Rst  input  1  reset; synchronous, active-high. Sampled on the rising edge of Clk.
- in_valid  input  1  fetch presents a word this cycle.
- in_inst  input  32  instruction word from instruction memory.
- in_pc4  input  32  PC+4 of that instruction, from the fetch adder.
- in_ready  output  1  queue can accept a word this cycle.
- flush  input  1  redirect from the branch/jump select; discards all contents.
- out_valid  output  1  head entry is valid.
- out_inst  output  32  head instruction word; 32'h0000_0000 when out_valid=0.
- out_pc4  output  32  head PC+4; 32'h0000_0000 when out_valid=0.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  PTRW+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage: two DEPTH-entry arrays, one 32-bit for instructions and one 32-bit for PC+4.
- Pointers: wr_ptr and rd_ptr, each PTRW bits, wrap modulo DEPTH. There is also a PTRW+1-bit occupancy register.
- push = in_valid & in_ready. Writes in_inst and in_pc4 at wr_ptr; wr_ptr advances by 1.
- pop = out_valid & out_ready. rd_ptr advances by 1.
- in_ready = (count != DEPTH) & ~Rst. It depends only on registered state and Rst, never on out_ready.
- Full queue: in_ready=0 even when a pop happens in the same cycle. No push-through when full.
- out_valid = (count != 0). out_inst and out_pc4 are the array entries at rd_ptr, gated to zero when count=0.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Flush (when Rst=0):
  - Next state is wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in the same cycle is discarded; flush dominates.
  - Array contents are left as they are. They are unobservable because the outputs are gated.
- Rst:
  - Same next state as flush, and it dominates flush.
  - Array contents are not reset.
- Occupancy states:
  - EMPTY (count=0): only push is possible.
  - PARTIAL (0<count<DEPTH): push and pop both allowed.
  - FULL (count=DEPTH): only pop is possible.
- No other FSM state exists.

## Timing
- Reset values, after any cycle in which Rst=1:
  - count=0, out_valid=0, out_inst=0, out_pc4=0.
  - in_ready=1 once Rst deasserts. in_ready is 0 while Rst=1.
- Latency from push to out_valid is 1 cycle: a word pushed at edge N appears on out_inst after edge N.
- No bypass from in_inst to out_inst in the same cycle.
- Throughput is 1 word per cycle when decode takes every cycle.
- Flush asserted at edge N:
  - After N: out_valid=0 and in_ready=1.
  - Fetch may push the redirected word in the cycle after N.
- Handshake stability:
  - out_inst and out_pc4 hold steady while out_valid=1 and out_ready=0.
  - The queue never requires in_valid or in_inst to hold steady; a word is captured only on push.
- Wrap-around:
  - Pointers roll from DEPTH−1 to 0 with no bubble.
  - FIFO order is preserved across the wrap.

## Test plan
- Reset then idle:
  - Stimulus: Rst=1 for 2 cycles, then Rst=0 with in_valid=0.
  - Required: out_valid=0, out_inst=0, out_pc4=0, count=0, in_ready=1.
- Streaming:
  - Stimulus: push 0x2001_0005/pc4 0x04, then 0x2002_0007/0x08, then 0x0022_1820/0x0C on consecutive cycles, with out_ready=1.
  - Required: each word appears 1 cycle after its push, in order; count stays at 1.
- Stall to full:
  - Stimulus: out_ready=0 and push 3 words with DEPTH=2.
  - Required: count=2 and in_ready=0 after 2 pushes; the third word is not accepted; out_inst holds the first word.
- Pop while full:
  - Stimulus: from FULL, out_ready=1 and in_valid=1.
  - Required: one pop, no push; count goes 2→1; in_ready=1 on the next cycle.
- Flush with simultaneous push and pop:
  - Stimulus: count=2 with flush=1, in_valid=1, out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_inst=0; the pushed word is lost.
- Wrap and Rst during flush:
  - Stimulus: push and pop 5 words, so the pointers wrap twice.
  - Required: order is preserved.
  - Stimulus: Rst=1 and flush=1 together.
  - Required: reset values, and in_ready=0 during Rst.
